mem_stage: RTL

MIPS MEM stage. Consumes the register-write triple and memory-op fields held by ex_mem_buffer. Performs loads and stores over a req/ack data bus and produces the writeback triple for mem_wb_buffer. Raises stall_req so the pipeline controller freezes upstream stages while a bus transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_load_align.sv | 27 ++
 rtl/mem_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: op codes, FSM states, access sizes.
package mem_stage_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0;

  // Access size of an op; unused codes 9-15 behave as NONE.
  function automatic size_e op_size(logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      OP_LW, OP_SW:         return SZ_WORD;
      default:              return SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data bus between the MEM stage (master) and memory (slave).
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  dbus_req;
  logic                  dbus_we;
  logic [ADDR_WIDTH-1:0] dbus_addr;
  logic [3:0]            dbus_sel;
  logic [DATA_WIDTH-1:0] dbus_wdata;
  logic [DATA_WIDTH-1:0] dbus_rdata;
  logic                  dbus_ack;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    input  dbus_rdata, dbus_ack
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_sel, dbus_wdata,
    output dbus_rdata, dbus_ack
  );
endinterface

// File: rtl/mem_load_align.sv
// Picks the addressed lane(s) out of a bus word and extends to 32 bits.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  lane,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane select then sign/zero extension by op.
  always_comb begin
    byte_v = rdata[{lane, 3'b000} +: 8];
    half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   result = {{24{byte_v[7]}}, byte_v};
      OP_LBU:  result = {24'h0, byte_v};
      OP_LH:   result = {{16{half_v[15]}}, half_v};
      OP_LHU:  result = {16'h0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: issues loads/stores on the data bus, stalls the pipe while
// a transaction is outstanding, and forms the writeback triple.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      mem_write_enable,
  input  logic [REG_ADDR_WIDTH-1:0] mem_write_addr,
  input  logic [DATA_WIDTH-1:0]     mem_write_data,
  input  logic [3:0]                mem_op,
  input  logic [ADDR_WIDTH-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0]     mem_store_data,
  output logic                      wb_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] wb_write_addr,
  output logic [DATA_WIDTH-1:0]     wb_write_data,
  output logic                      stall_req,
  output logic                      addr_error,
  mem_stage_if.master               dbus
);

  state_e                    state_q;
  logic [3:0]                op_q;
  logic [1:0]                lane_q;
  logic [REG_ADDR_WIDTH-1:0] rd_q;
  logic                      en_q;
  logic [DATA_WIDTH-1:0]     result_q;
  logic                      req_q, we_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [3:0]                sel_q;
  logic [DATA_WIDTH-1:0]     wdata_q;

  size_e                     sz;
  logic                      misaligned, mem_go;
  logic [3:0]                sel_d;
  logic [DATA_WIDTH-1:0]     wdata_d;
  logic [DATA_WIDTH-1:0]     load_result;

  // Decode the incoming op: alignment, lane enables and replicated store data.
  always_comb begin
    sz         = op_size(mem_op);
    misaligned = ((sz == SZ_HALF) && mem_addr[0]) ||
                 ((sz == SZ_WORD) && (mem_addr[1:0] != 2'b00));
    mem_go     = (sz != SZ_NONE) && !misaligned;
    case (sz)
      SZ_BYTE: begin
        sel_d   = 4'b0001 << mem_addr[1:0];
        wdata_d = {4{mem_store_data[7:0]}};
      end
      SZ_HALF: begin
        sel_d   = mem_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{mem_store_data[15:0]}};
      end
      SZ_WORD: begin
        sel_d   = 4'b1111;
        wdata_d = mem_store_data;
      end
      default: begin
        sel_d   = 4'b0000;
        wdata_d = mem_store_data;
      end
    endcase
  end

  mem_load_align u_align (
    .op    (op_q),
    .lane  (lane_q),
    .rdata (dbus.dbus_rdata),
    .result(load_result)
  );

  // Transaction FSM; bus outputs are registered and held for the whole BUSY phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_NONE;
      lane_q   <= 2'b00;
      rd_q     <= '0;
      en_q     <= DISABLE;
      result_q <= ZERO_WORD;
      req_q    <= DISABLE;
      we_q     <= DISABLE;
      addr_q   <= '0;
      sel_q    <= 4'b0000;
      wdata_q  <= ZERO_WORD;
    end else begin
      case (state_q)
        ST_IDLE: if (mem_go) begin
          state_q <= ST_BUSY;
          op_q    <= mem_op;
          lane_q  <= mem_addr[1:0];
          rd_q    <= mem_write_addr;
          en_q    <= mem_write_enable;
          req_q   <= ENABLE;
          we_q    <= op_is_store(mem_op);
          addr_q  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
          sel_q   <= sel_d;
          wdata_q <= wdata_d;
        end
        ST_BUSY: if (dbus.dbus_ack) begin
          result_q <= load_result;
          req_q    <= DISABLE;
          state_q  <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dbus.dbus_req   = req_q;
  assign dbus.dbus_we    = we_q;
  assign dbus.dbus_addr  = addr_q;
  assign dbus.dbus_sel   = sel_q;
  assign dbus.dbus_wdata = wdata_q;

  // Writeback/stall: pass-through for non-memory ops, latched result once done.
  always_comb begin
    wb_write_enable = DISABLE;
    wb_write_addr   = '0;
    wb_write_data   = ZERO_WORD;
    stall_req       = DISABLE;
    addr_error      = DISABLE;
    case (state_q)
      ST_IDLE: begin
        if (misaligned) begin
          addr_error = ENABLE;
        end else if (mem_go) begin
          stall_req = ENABLE;
        end else begin
          wb_write_enable = mem_write_enable;
          wb_write_addr   = mem_write_addr;
          wb_write_data   = mem_write_data;
        end
      end
      ST_BUSY: stall_req = ENABLE;
      default: begin
        wb_write_enable = en_q && !we_q;
        wb_write_addr   = rd_q;
        wb_write_data   = result_q;
      end
    endcase
  end

endmodule
